// File: rtl/req_gnt_checker.sv
// req_gnt_checker: per-channel req/gnt protocol monitor. Measures grant latency
// against [MIN_LAT, MAX_LAT] and keeps sticky error flags plus saturating counters.
module req_gnt_checker #(
    parameter int N_CH    = 4,
    parameter int MIN_LAT = 1,
    parameter int MAX_LAT = 8,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  req,
    input  logic [N_CH-1:0]  gnt,
    input  logic             clr,
    output logic [N_CH-1:0]  active,
    output logic [N_CH-1:0]  err_early,
    output logic [N_CH-1:0]  err_timeout,
    output logic [N_CH-1:0]  err_drop,
    output logic [N_CH-1:0]  err_spurious,
    output logic             err_any,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int LAT_W = $clog2(MAX_LAT + 1);
    // Wide enough to hold a saturated counter plus one event from every channel.
    localparam int SUM_W = CNT_W + $clog2(N_CH + 1);
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    logic [N_CH-1:0] ev_pass;
    logic [N_CH-1:0] ev_early;
    logic [N_CH-1:0] ev_timeout;
    logic [N_CH-1:0] ev_drop;
    logic [N_CH-1:0] ev_spur;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t           state;
        logic [LAT_W-1:0] lat;
        logic             act_q;
        logic             e_pass, e_early, e_timeout, e_drop, e_spur;

        always_comb begin
            // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
            e_pass    = 1'b0;
            e_early   = 1'b0;
            e_timeout = 1'b0;
            e_drop    = 1'b0;
            e_spur    = 1'b0;
            case (state)
                IDLE: begin
                    if (gnt[i]) begin
                        if (!req[i])            e_spur  = 1'b1;
                        else if (MIN_LAT == 0)  e_pass  = 1'b1;
                        else                    e_early = 1'b1;
                    end
                end
                WAIT: begin
                    if (gnt[i]) begin
                        if (int'(lat) >= MIN_LAT) e_pass  = 1'b1;
                        else                      e_early = 1'b1;
                    end else if (!req[i]) begin
                        e_drop = 1'b1;
                    end else if (lat == LAT_MAX) begin
                        e_timeout = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
                state <= IDLE;
                lat   <= '0;
                act_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (req[i] && !gnt[i]) begin
                            state <= WAIT;
                            lat   <= LAT_W'(1);
                            act_q <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (gnt[i] || !req[i] || lat == LAT_MAX) begin
                            state <= IDLE;
                            lat   <= '0;
                            act_q <= 1'b0;
                        end else begin
                            lat <= lat + LAT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        lat   <= '0;
                        act_q <= 1'b0;
                    end
                endcase
            end
        end

        assign active[i]     = act_q;
        assign ev_pass[i]    = e_pass;
        assign ev_early[i]   = e_early;
        assign ev_timeout[i] = e_timeout;
        assign ev_drop[i]    = e_drop;
        assign ev_spur[i]    = e_spur;
    end

    logic [N_CH-1:0]  early_nxt, timeout_nxt, drop_nxt, spur_nxt;
    logic [SUM_W-1:0] n_pass, n_err, pass_sum, err_sum;
    logic [CNT_W-1:0] pass_nxt, err_nxt;

    // clr clears the old value, but events on the same edge still land.
    always_comb begin
        early_nxt   = (clr ? '0 : err_early)    | ev_early;
        timeout_nxt = (clr ? '0 : err_timeout)  | ev_timeout;
        drop_nxt    = (clr ? '0 : err_drop)     | ev_drop;
        spur_nxt    = (clr ? '0 : err_spurious) | ev_spur;

        n_pass = '0;
        n_err  = '0;
        for (int i = 0; i < N_CH; i++) begin
            n_pass = n_pass + SUM_W'(ev_pass[i]);
            n_err  = n_err + SUM_W'(ev_early[i] | ev_timeout[i] | ev_drop[i] | ev_spur[i]);
        end

        pass_sum = (clr ? '0 : SUM_W'(pass_cnt)) + n_pass;
        err_sum  = (clr ? '0 : SUM_W'(err_cnt)) + n_err;
        pass_nxt = (pass_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : pass_sum[CNT_W-1:0];
        err_nxt  = (err_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : err_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_early    <= '0;
            err_timeout  <= '0;
            err_drop     <= '0;
            err_spurious <= '0;
            err_any      <= 1'b0;
            pass_cnt     <= '0;
            err_cnt      <= '0;
        end else begin
            err_early    <= early_nxt;
            err_timeout  <= timeout_nxt;
            err_drop     <= drop_nxt;
            err_spurious <= spur_nxt;
            err_any      <= |{early_nxt, timeout_nxt, drop_nxt, spur_nxt};
            pass_cnt     <= pass_nxt;
            err_cnt      <= err_nxt;
        end
    end

endmodule

// File: tb/tb_req_gnt_checker.sv
// Randomised and directed bench for req_gnt_checker; two configurations share
// stimulus and are checked against a transaction-level reference model.
module tb_req_gnt_checker;

    localparam int N = 4;
    localparam int A_MIN = 1, A_MAX = 8, A_CW = 8;
    localparam int B_MIN = 0, B_MAX = 5, B_CW = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req, gnt;
    logic         clr;

    logic [N-1:0]      a_active, a_early, a_timeout, a_drop, a_spur;
    logic              a_any;
    logic [A_CW-1:0]   a_pass_cnt, a_err_cnt;
    logic [N-1:0]      b_active, b_early, b_timeout, b_drop, b_spur;
    logic              b_any;
    logic [B_CW-1:0]   b_pass_cnt, b_err_cnt;

    req_gnt_checker #(.N_CH(N), .MIN_LAT(A_MIN), .MAX_LAT(A_MAX), .CNT_W(A_CW)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .clr(clr),
        .active(a_active), .err_early(a_early), .err_timeout(a_timeout),
        .err_drop(a_drop), .err_spurious(a_spur), .err_any(a_any),
        .pass_cnt(a_pass_cnt), .err_cnt(a_err_cnt)
    );

    req_gnt_checker #(.N_CH(N), .MIN_LAT(B_MIN), .MAX_LAT(B_MAX), .CNT_W(B_CW)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .clr(clr),
        .active(b_active), .err_early(b_early), .err_timeout(b_timeout),
        .err_drop(b_drop), .err_spurious(b_spur), .err_any(b_any),
        .pass_cnt(b_pass_cnt), .err_cnt(b_err_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a request is remembered by the cycle it started on;
    // latency is just the difference between cycle numbers.
    int           m_start [2][N];
    int           m_cyc;
    bit [N-1:0]   m_act [2], m_early [2], m_tmo [2], m_drop [2], m_spur [2];
    int           m_pass [2], m_err [2];

    function automatic int cfg_min(int k); return (k == 0) ? A_MIN : B_MIN; endfunction
    function automatic int cfg_max(int k); return (k == 0) ? A_MAX : B_MAX; endfunction
    function automatic int cfg_top(int k); return (k == 0) ? (1 << A_CW) - 1 : (1 << B_CW) - 1; endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) m_start[k][i] = -1;
            m_act[k] = '0; m_early[k] = '0; m_tmo[k] = '0; m_drop[k] = '0; m_spur[k] = '0;
            m_pass[k] = 0; m_err[k] = 0;
        end
        m_cyc = 0;
    endtask

    task automatic model_edge(input int k);
        int np = 0, ne = 0, lat;
        if (clr) begin
            m_early[k] = '0; m_tmo[k] = '0; m_drop[k] = '0; m_spur[k] = '0;
            m_pass[k] = 0; m_err[k] = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (m_start[k][i] < 0) begin
                if (gnt[i] && req[i]) begin
                    if (cfg_min(k) == 0) np++;
                    else begin m_early[k][i] = 1'b1; ne++; end
                end else if (gnt[i]) begin
                    m_spur[k][i] = 1'b1; ne++;
                end else if (req[i]) begin
                    m_start[k][i] = m_cyc;
                end
            end else begin
                lat = m_cyc - m_start[k][i];
                if (gnt[i]) begin
                    if (lat >= cfg_min(k)) np++;
                    else begin m_early[k][i] = 1'b1; ne++; end
                    m_start[k][i] = -1;
                end else if (!req[i]) begin
                    m_drop[k][i] = 1'b1; ne++;
                    m_start[k][i] = -1;
                end else if (lat == cfg_max(k)) begin
                    m_tmo[k][i] = 1'b1; ne++;
                    m_start[k][i] = -1;
                end
            end
            m_act[k][i] = (m_start[k][i] >= 0);
        end
        m_pass[k] = (m_pass[k] + np > cfg_top(k)) ? cfg_top(k) : m_pass[k] + np;
        m_err[k]  = (m_err[k] + ne > cfg_top(k)) ? cfg_top(k) : m_err[k] + ne;
    endtask

    task automatic compare_all();
        check("a_active",  32'(a_active),   32'(m_act[0]));
        check("a_early",   32'(a_early),    32'(m_early[0]));
        check("a_timeout", 32'(a_timeout),  32'(m_tmo[0]));
        check("a_drop",    32'(a_drop),     32'(m_drop[0]));
        check("a_spur",    32'(a_spur),     32'(m_spur[0]));
        check("a_any",     32'(a_any),      32'(|{m_early[0], m_tmo[0], m_drop[0], m_spur[0]}));
        check("a_pass",    32'(a_pass_cnt), 32'(m_pass[0]));
        check("a_err",     32'(a_err_cnt),  32'(m_err[0]));
        check("b_active",  32'(b_active),   32'(m_act[1]));
        check("b_early",   32'(b_early),    32'(m_early[1]));
        check("b_timeout", 32'(b_timeout),  32'(m_tmo[1]));
        check("b_drop",    32'(b_drop),     32'(m_drop[1]));
        check("b_spur",    32'(b_spur),     32'(m_spur[1]));
        check("b_any",     32'(b_any),      32'(|{m_early[1], m_tmo[1], m_drop[1], m_spur[1]}));
        check("b_pass",    32'(b_pass_cnt), 32'(m_pass[1]));
        check("b_err",     32'(b_err_cnt),  32'(m_err[1]));
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] g, input logic c);
        req = r; gnt = g; clr = c;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        m_cyc++;
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [N-1:0] r, g;

    initial begin
        rst_n = 1'b0; req = '0; gnt = '0; clr = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset then idle.
        repeat (10) step('0, '0, 1'b0);
        check("idle_pass", 32'(a_pass_cnt), 32'd0);

        // Legal grant on ch0 at latency 2.
        step(4'b0001, '0, 1'b0);
        step(4'b0001, '0, 1'b0);
        step(4'b0001, 4'b0001, 1'b0);
        check("legal_pass", 32'(a_pass_cnt), 32'd1);
        step('0, '0, 1'b0);

        // Timeout on ch1 (edges 0..8), then a restarted request.
        repeat (9) step(4'b0010, '0, 1'b0);
        check("tmo_flag", 32'(a_timeout), 32'h2);
        check("tmo_cnt",  32'(a_err_cnt), 32'd1);
        repeat (3) step(4'b0010, '0, 1'b0);
        step('0, '0, 1'b0);
        step('0, '0, 1'b1);

        // Drop on ch3 at latency 3, then spurious grant on ch2.
        repeat (3) step(4'b1000, '0, 1'b0);
        step('0, '0, 1'b0);
        step('0, 4'b0100, 1'b0);
        check("drop_spur_cnt", 32'(a_err_cnt), 32'd2);
        check("drop_spur_any", 32'(a_any), 32'd1);

        // Same-edge req&gnt, then four simultaneous grants.
        step(4'b0001, 4'b0001, 1'b1);
        check("early_flag", 32'(a_early), 32'h1);
        step('0, '0, 1'b1);
        step(4'b1111, '0, 1'b0);
        step(4'b1111, '0, 1'b0);
        step(4'b1111, 4'b1111, 1'b0);
        check("all4_pass", 32'(a_pass_cnt), 32'd4);
        check("sat_pass",  32'(b_pass_cnt), 32'd3);
        step('0, '0, 1'b0);

        // clr on the timeout edge of ch1.
        repeat (8) step(4'b0010, '0, 1'b0);
        step(4'b0010, '0, 1'b1);
        check("clr_tmo_cnt",  32'(a_err_cnt), 32'd1);
        check("clr_tmo_flag", 32'(a_timeout), 32'h2);
        step('0, '0, 1'b0);

        // Reset mid-WAIT, then req held low.
        repeat (3) step(4'b0101, '0, 1'b0);
        do_reset();
        repeat (5) step('0, '0, 1'b0);
        check("rst_any",    32'(a_any),     32'd0);
        check("rst_active", 32'(a_active),  32'd0);
        check("rst_errcnt", 32'(a_err_cnt), 32'd0);

        // Random traffic.
        r = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) r[i] = ~r[i];
            g = '0;
            for (int i = 0; i < N; i++) if ($urandom_range(5) == 0) g[i] = 1'b1;
            step(r, g, ($urandom_range(49) == 0));
            if ($urandom_range(499) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
